nor_logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the single 2-input NOR gate.
- Applies a selectable bitwise two-operand logic function (NOR default) across WIDTH-bit operands.
- Buffers results in a DEPTH-entry output queue with valid/ready handshakes on both sides.
- Sits between any operand producer and consumer in the structural-modelling exercise designs. It also provides a zero flag and a completed-operation counter.

---
 rtl/nor_logic_unit_pipe.sv | 95 +++++++++
 tb/tb_nor_logic_unit_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nor_logic_unit_pipe.sv
// Registered bitwise two-operand logic unit (NOR by default) feeding a
// DEPTH-entry result queue with valid/ready on both sides, a zero flag and an op counter.
module nor_logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QCNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    M_NOR  = 3'b000,
    M_OR   = 3'b001,
    M_NAND = 3'b010,
    M_AND  = 3'b011,
    M_XOR  = 3'b100,
    M_XNOR = 3'b101,
    M_NOT  = 3'b110,
    M_PASS = 3'b111
  } mode_e;

  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [QCNT_W-1:0] count;
  logic              armed;
  logic              push, pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    result = '0;
    case (mode_e'(mode))
      M_NOR:   result = ~(a | b);
      M_OR:    result = a | b;
      M_NAND:  result = ~(a & b);
      M_AND:   result = a & b;
      M_XOR:   result = a ^ b;
      M_XNOR:  result = ~(a ^ b);
      M_NOT:   result = ~a;
      M_PASS:  result = a;
      default: result = '0;
    endcase
  end

  // armed keeps in_ready low during reset and until the first edge after release.
  assign in_ready  = armed & (count != QCNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign y         = out_valid ? mem[rd_ptr] : '0;
  assign y_zero    = out_valid & ~|y;

  // NOTE: the storage array has no reset; out_valid gates y, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      armed    <= 1'b0;
      op_count <= '0;
    end else begin
      armed <= 1'b1;
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        op_count <= op_count + CNT_W'(1);
      end
      if (push && !pop)
        count <= count + QCNT_W'(1);
      else if (pop && !push)
        count <= count - QCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nor_logic_unit_pipe.sv
// Randomised and directed bench for nor_logic_unit_pipe against a queue-based
// model of the result FIFO, op counter and ready/valid rules.
module tb_nor_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic [2:0]       mode = '0;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic             in_ready, y_zero, out_valid;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;

  nor_logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .y_zero(y_zero),
    .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(logic [WIDTH-1:0] x, logic [WIDTH-1:0] z, int m);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int s;
      s = int'(x[i]) + int'(z[i]);
      case (m)
        0: r[i] = (s == 0);
        1: r[i] = (s >= 1);
        2: r[i] = (s != 2);
        3: r[i] = (s == 2);
        4: r[i] = (s == 1);
        5: r[i] = (s != 1);
        6: r[i] = !x[i];
        default: r[i] = x[i];
      endcase
    end
    return r;
  endfunction

  // Behavioural model: a queue of pending results and a handshake tally.
  logic [WIDTH-1:0] q[$];
  int  m_ops   = 0;
  bit  m_armed = 0;
  bit  hin, hout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ops   = 0;
      m_armed = 0;
    end else begin
      hin  = in_valid && m_armed && (q.size() < DEPTH);
      hout = (q.size() != 0) && out_ready;
      if (hout) begin
        void'(q.pop_front());
        m_ops++;
      end
      if (hin) q.push_back(ref_op(a, b, int'(mode)));
      m_armed = 1;
    end
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, m_armed && (q.size() < DEPTH)});
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("y",         {24'd0, y},         {24'd0, (q.size() != 0) ? q[0] : 8'h00});
      check("y_zero",    {31'd0, y_zero},    {31'd0, (q.size() != 0) && (q[0] == 8'h00)});
      check("op_count",  {24'd0, op_count},  m_ops % 256);
    end
  end

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] mv, input logic rdy);
    @(negedge clk);
    in_valid = v; a = av; b = bv; mode = mv; out_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
  endtask

  logic [7:0] sweep_exp [8] = '{8'h03, 8'hFC, 8'h3F, 8'hC0, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
  int start_cnt;

  initial begin
    // Reset held with live offers
    in_valid = 1'b1; a = 8'h3C; b = 8'h5A; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {31'd0, out_valid}, 0);
    check("rst y",         {24'd0, y},         0);
    check("rst op_count",  {24'd0, op_count},  0);
    check("rst in_ready",  {31'd0, in_ready},  0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst in_ready", {31'd0, in_ready}, 1);

    // Single NOR
    drive(1'b1, 8'hA5, 8'h0F, 3'd0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check("nor valid", {31'd0, out_valid}, 1);
    check("nor y",     {24'd0, y},         32'h50);
    check("nor zero",  {31'd0, y_zero},    0);
    @(negedge clk);
    check("nor count", {24'd0, op_count},  1);

    // Mode sweep, one per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1);
      if (i > 0) begin
        check("sweep valid", {31'd0, out_valid}, 1);
        check("sweep y", {24'd0, y}, {24'd0, sweep_exp[i-1]});
      end
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check("sweep y last", {24'd0, y}, 32'hF0);
    idle(1);

    // Back-pressure and full queue
    drive(1'b1, 8'h11, 8'h00, 3'd7, 1'b0);
    drive(1'b1, 8'h22, 8'h00, 3'd7, 1'b0);
    check("bp y1", {24'd0, y}, 32'h11);
    drive(1'b1, 8'h33, 8'h00, 3'd7, 1'b0);
    check("bp full", {31'd0, in_ready}, 0);
    check("bp y2",   {24'd0, y},        32'h11);
    drive(1'b0, 8'h00, 8'h00, 3'd7, 1'b1);
    check("bp held", {24'd0, y},        32'h11);
    check("bp still full", {31'd0, in_ready}, 0);
    @(negedge clk);
    check("drain y2",      {24'd0, y},        32'h22);
    check("drain ready",   {31'd0, in_ready}, 1);
    @(negedge clk);
    check("drain empty",   {31'd0, out_valid}, 0);

    // Zero flag then simultaneous push/pop at count==1
    drive(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
    drive(1'b1, 8'h5A, 8'h00, 3'd7, 1'b1);
    check("zero y",    {24'd0, y},      0);
    check("zero flag", {31'd0, y_zero}, 1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check("pp valid",  {31'd0, out_valid}, 1);
    check("pp y",      {24'd0, y},         32'h5A);
    @(negedge clk);
    check("pp empty",  {31'd0, out_valid}, 0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    idle(4);

    // Counter wrap: 256 more handshakes return op_count to its start value
    start_cnt = int'(op_count);
    for (int i = 0; i < 256; i++) drive(1'b1, 8'($urandom), 8'($urandom), 3'd0, 1'b1);
    idle(3);
    check("wrap", {24'd0, op_count}, start_cnt);

    // Mid-cycle reset with two queued entries
    drive(1'b1, 8'h81, 8'h00, 3'd7, 1'b0);
    drive(1'b1, 8'h82, 8'h00, 3'd7, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async valid", {31'd0, out_valid}, 0);
    check("async y",     {24'd0, y},         0);
    check("async cnt",   {24'd0, op_count},  0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("no stale", {31'd0, out_valid}, 0);
    drive(1'b1, 8'h0F, 8'h0F, 3'd4, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    check("post-rst y",    {24'd0, y},      0);
    check("post-rst zero", {31'd0, y_zero}, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
